// File: rtl/mpq_cmd_sched_if.sv
// Requester/MPQ-side signal bundle for the MPQ command scheduler.
// slave: the scheduler. master: the requesters together with the MPQ engine.
interface mpq_cmd_sched_if;
  logic       a_valid, a_ready;
  logic [2:0] a_cmd;
  logic [7:0] a_index, a_value;
  logic       b_valid, b_ready;
  logic [2:0] b_cmd;
  logic [7:0] b_index, b_value;
  logic       mpq_busy, mpq_done;
  logic       mpq_cmd_valid;
  logic [2:0] mpq_cmd;
  logic [7:0] mpq_index, mpq_value;
  logic       grant_b, seq_done;
  logic [4:0] a_count, b_count;

  modport slave (
    input  a_valid, a_cmd, a_index, a_value,
    input  b_valid, b_cmd, b_index, b_value,
    input  mpq_busy, mpq_done,
    output a_ready, b_ready, mpq_cmd_valid, mpq_cmd, mpq_index, mpq_value,
    output grant_b, seq_done, a_count, b_count
  );

  modport master (
    output a_valid, a_cmd, a_index, a_value,
    output b_valid, b_cmd, b_index, b_value,
    output mpq_busy, mpq_done,
    input  a_ready, b_ready, mpq_cmd_valid, mpq_cmd, mpq_index, mpq_value,
    input  grant_b, seq_done, a_count, b_count
  );
endinterface

// File: rtl/mpq_cmd_sched.sv
// Two-source command FIFOs with round-robin issue to the MPQ engine;
// write-out commands hold off further issue until MPQ signals done.
module mpq_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 19
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic         o_ready,
  output logic [W-1:0] o_head,
  output logic [4:0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] r_mem;
  logic [AW-1:0]           r_wp, r_rp;
  logic [4:0]              r_count;
  logic                    w_push, w_pop;

  // ready depends only on the registered count, so a full FIFO refuses
  // a push even when the same edge pops an entry
  assign o_ready = !rst && (r_count < 5'(DEPTH));
  assign w_push  = i_push && o_ready;
  assign w_pop   = i_pop && (r_count != 5'd0);
  assign o_head  = r_mem[r_rp];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= i_data;
        r_wp        <= r_wp + AW'(1);
      end
      if (w_pop) r_rp <= r_rp + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module mpq_cmd_sched #(
  parameter int         DEPTH   = 4,
  parameter int         TIMEOUT = 2,
  parameter logic [2:0] WR_CMD  = 3'd4
) (
  input logic            clk,
  input logic            rst,
  mpq_cmd_sched_if.slave bus
);
  typedef struct packed {
    logic [2:0] cmd;
    logic [7:0] index;
    logic [7:0] value;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, WAIT, BUSY, FLUSH} state_t;

  localparam int CW = $clog2(TIMEOUT + 1);

  cmd_t [1:0]      w_in, w_head;
  logic [1:0]      w_push, w_pop, w_ready, w_nempty;
  logic [1:0][4:0] w_count;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            w_issue, w_sel_b, w_seq_done_nxt;
  logic            r_vld, r_grant_b, r_seq_done;
  cmd_t            r_out;

  assign w_in[0]  = {bus.a_cmd, bus.a_index, bus.a_value};
  assign w_in[1]  = {bus.b_cmd, bus.b_index, bus.b_value};
  assign w_push   = {bus.b_valid, bus.a_valid};
  assign w_pop    = {w_issue & w_sel_b, w_issue & ~w_sel_b};

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_src
      mpq_cmd_fifo #(.DEPTH(DEPTH), .W($bits(cmd_t))) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push[g]),
        .i_data  (w_in[g]),
        .i_pop   (w_pop[g]),
        .o_ready (w_ready[g]),
        .o_head  (w_head[g]),
        .o_count (w_count[g])
      );
      assign w_nempty[g] = (w_count[g] != 5'd0);
    end
  endgenerate

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_issue        = 1'b0;
    w_sel_b        = 1'b0;
    w_seq_done_nxt = 1'b0;
    case (r_state)
      IDLE: if (!bus.mpq_busy && (|w_nempty)) begin
        w_issue     = 1'b1;
        // on a tie the source that did not win last time goes next
        w_sel_b     = (&w_nempty) ? ~r_grant_b : w_nempty[1];
        w_cnt_nxt   = CW'(1);
        w_state_nxt = (w_head[w_sel_b].cmd == WR_CMD) ? FLUSH : WAIT;
      end
      WAIT: begin
        if (bus.mpq_busy)                w_state_nxt = BUSY;
        else if (r_cnt >= CW'(TIMEOUT))  w_state_nxt = IDLE;
        else                             w_cnt_nxt   = r_cnt + CW'(1);
      end
      BUSY: if (!bus.mpq_busy) w_state_nxt = IDLE;
      FLUSH: if (bus.mpq_done) begin
        w_seq_done_nxt = 1'b1;
        w_state_nxt    = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_vld      <= 1'b0;
      r_out      <= '0;
      r_grant_b  <= 1'b1;
      r_seq_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_vld      <= w_issue;
      r_out      <= w_issue ? w_head[w_sel_b] : '0;
      r_seq_done <= w_seq_done_nxt;
      if (w_issue) r_grant_b <= w_sel_b;
    end
  end

  assign bus.a_ready       = w_ready[0];
  assign bus.b_ready       = w_ready[1];
  assign bus.a_count       = w_count[0];
  assign bus.b_count       = w_count[1];
  assign bus.mpq_cmd_valid = r_vld;
  assign bus.mpq_cmd       = r_out.cmd;
  assign bus.mpq_index     = r_out.index;
  assign bus.mpq_value     = r_out.value;
  assign bus.grant_b       = r_grant_b;
  assign bus.seq_done      = r_seq_done;
endmodule

// File: tb/tb_mpq_cmd_sched.sv
// Scoreboard bench for mpq_cmd_sched: accepted pushes feed per-source queues,
// each issue is matched against a round-robin model; directed timing checks.
module tb_mpq_cmd_sched;
  localparam int         DEPTH   = 4;
  localparam int         TIMEOUT = 2;
  localparam logic [2:0] WR_CMD  = 3'd4;

  typedef struct packed {
    logic [2:0] cmd;
    logic [7:0] idx;
    logic [7:0] val;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  mpq_cmd_sched_if bus();

  mpq_cmd_sched #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .WR_CMD(WR_CMD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0, n_err = 0, cyc = 0;
  ent_t qa[$], qb[$];
  int   st_cyc[$], st_grant[$], sd_cyc[$], pa_cyc[$];
  bit   pend_rst = 1'b1, pa = 1'b0, pb = 1'b0, m_grant = 1'b1, sel;
  ent_t pa_d, pb_d, e;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // monitor on the falling edge: outputs reflect the preceding rising edge,
  // inputs are the values the next rising edge will capture
  always @(negedge clk) begin
    cyc++;
    if (pend_rst) begin
      qa.delete(); qb.delete(); m_grant = 1'b1;
      chk("rst_vld",    bus.mpq_cmd_valid, 0);
      chk("rst_fields", {bus.mpq_cmd, bus.mpq_index, bus.mpq_value}, 0);
      chk("rst_acnt",   bus.a_count, 0);
      chk("rst_bcnt",   bus.b_count, 0);
      chk("rst_grant",  bus.grant_b, 1);
      chk("rst_sd",     bus.seq_done, 0);
    end else begin
      if (bus.mpq_cmd_valid) begin
        st_cyc.push_back(cyc);
        st_grant.push_back(int'(bus.grant_b));
        if (qa.size() == 0 && qb.size() == 0) begin
          chk("spurious_issue", bus.mpq_cmd_valid, 0);
        end else begin
          sel = (qa.size() != 0 && qb.size() != 0) ? !m_grant : (qb.size() != 0);
          e   = sel ? qb.pop_front() : qa.pop_front();
          m_grant = sel;
          chk("iss_grant", bus.grant_b, sel);
          chk("iss_cmd",   bus.mpq_cmd, e.cmd);
          chk("iss_idx",   bus.mpq_index, e.idx);
          chk("iss_val",   bus.mpq_value, e.val);
        end
      end else begin
        chk("idle_fields", {bus.mpq_cmd, bus.mpq_index, bus.mpq_value}, 0);
      end
      if (pa) qa.push_back(pa_d);
      if (pb) qb.push_back(pb_d);
      chk("acnt",  bus.a_count, qa.size());
      chk("bcnt",  bus.b_count, qb.size());
      chk("grant", bus.grant_b, m_grant);
      if (bus.seq_done) sd_cyc.push_back(cyc);
    end
    pend_rst = rst;
    pa   = bus.a_valid & bus.a_ready;
    pb   = bus.b_valid & bus.b_ready;
    pa_d = {bus.a_cmd, bus.a_index, bus.a_value};
    pb_d = {bus.b_cmd, bus.b_index, bus.b_value};
    if (pa) pa_cyc.push_back(cyc + 1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic drv_a(input bit v, input logic [2:0] c, input logic [7:0] i, input logic [7:0] d);
    bus.a_valid = v; bus.a_cmd = c; bus.a_index = i; bus.a_value = d;
  endtask

  task automatic drv_b(input bit v, input logic [2:0] c, input logic [7:0] i, input logic [7:0] d);
    bus.b_valid = v; bus.b_cmd = c; bus.b_index = i; bus.b_value = d;
  endtask

  task automatic wait_st(input int n, input int budget);
    int k = 0;
    while (st_cyc.size() < n && k < budget) begin tick(); k++; end
    if (st_cyc.size() < n) chk("strobe_timeout", st_cyc.size(), n);
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.mpq_busy = 1'b0; bus.mpq_done = 1'b0;
    drv_a(0, 0, 0, 0); drv_b(0, 0, 0, 0);
    ticks(2);
    rst = 1'b0;
    tick();
  endtask

  int t_clr, n0;

  initial begin
    drv_a(0, 0, 0, 0); drv_b(0, 0, 0, 0);
    bus.mpq_busy = 1'b0; bus.mpq_done = 1'b0;
    ticks(3);
    chk("rst_ardy", bus.a_ready, 0);
    chk("rst_brdy", bus.b_ready, 0);
    rst = 1'b0;
    tick();
    chk("ardy_post", bus.a_ready, 1);
    chk("brdy_post", bus.b_ready, 1);

    // A only, busy never rises
    st_cyc.delete(); st_grant.delete(); pa_cyc.delete();
    drv_a(1, 3'd1, 8'd0, 8'd0); tick();
    drv_a(1, 3'd2, 8'd3, 8'd9); tick();
    drv_a(0, 0, 0, 0);
    wait_st(2, 20);
    if (st_cyc.size() >= 2) begin
      chk("t1_gap",   st_cyc[1] - st_cyc[0], TIMEOUT + 1);
      chk("t1_lat",   st_cyc[0] - pa_cyc[0], 1);
      chk("t1_grant", st_grant[1], 0);
    end
    ticks(5);

    // both sources, two entries each
    do_reset();
    st_cyc.delete(); st_grant.delete();
    drv_a(1, 3'd1, 8'd1, 8'd1); drv_b(1, 3'd2, 8'd2, 8'd2); tick();
    drv_a(1, 3'd3, 8'd3, 8'd3); drv_b(1, 3'd5, 8'd5, 8'd5); tick();
    drv_a(0, 0, 0, 0); drv_b(0, 0, 0, 0);
    wait_st(4, 40);
    for (int i = 0; i < st_grant.size() && i < 4; i++) chk("t2_rr", st_grant[i], i % 2);
    ticks(4);

    // busy handshake holds off the next issue
    st_cyc.delete();
    drv_a(1, 3'd1, 8'd7, 8'd7); tick(); drv_a(0, 0, 0, 0);
    wait_st(1, 10);
    bus.mpq_busy = 1'b1;
    drv_a(1, 3'd2, 8'd8, 8'd8); tick(); drv_a(0, 0, 0, 0);
    ticks(4);
    n0 = st_cyc.size();
    bus.mpq_busy = 1'b0; t_clr = cyc;
    wait_st(2, 20);
    chk("t3_noissue", n0, 1);
    if (st_cyc.size() >= 2) chk("t3_resume", st_cyc[1], t_clr + 3);
    ticks(4);

    // fill A while busy blocks issue
    bus.mpq_busy = 1'b1; tick();
    st_cyc.delete();
    for (int i = 0; i < 5; i++) begin
      drv_a(1, 3'(i % 3 + 1), 8'(i), 8'(16 + i)); tick();
      if (i == 3) begin
        chk("t4_rdy", bus.a_ready, 0);
        chk("t4_cnt", bus.a_count, DEPTH);
      end
    end
    chk("t4_noissue", st_cyc.size(), 0);
    bus.mpq_busy = 1'b0; tick();
    drv_a(0, 0, 0, 0);
    chk("t4_fullpop", bus.a_count, DEPTH - 1);
    wait_st(4, 40);
    ticks(6);
    chk("t4_total", st_cyc.size(), 4);

    // write-out waits for done, busy ignored meanwhile
    st_cyc.delete(); sd_cyc.delete();
    drv_a(1, WR_CMD, 8'h11, 8'h22); tick(); drv_a(0, 0, 0, 0);
    wait_st(1, 10);
    drv_b(1, 3'd2, 8'h33, 8'h44); tick(); drv_b(0, 0, 0, 0);
    bus.mpq_busy = 1'b1; ticks(3);
    bus.mpq_busy = 1'b0; ticks(4);
    chk("t5_noissue", st_cyc.size(), 1);
    bus.mpq_done = 1'b1; t_clr = cyc; tick();
    bus.mpq_done = 1'b0;
    wait_st(2, 20);
    chk("t5_sd_n", sd_cyc.size(), 1);
    if (sd_cyc.size() >= 1) chk("t5_sd_t", sd_cyc[0], t_clr + 2);
    if (st_cyc.size() >= 2) chk("t5_b_iss", st_cyc[1], t_clr + 3);
    ticks(6);
    bus.mpq_done = 1'b1; tick(); bus.mpq_done = 1'b0;
    ticks(3);
    chk("t5_done_ign", sd_cyc.size(), 1);

    // reset while BUSY with three entries queued
    st_cyc.delete();
    drv_a(1, 3'd1, 8'd1, 8'd2); tick(); drv_a(0, 0, 0, 0);
    wait_st(1, 10);
    bus.mpq_busy = 1'b1;
    drv_a(1, 3'd2, 8'd3, 8'd4); drv_b(1, 3'd3, 8'd5, 8'd6); tick();
    drv_a(0, 0, 0, 0); drv_b(1, 3'd1, 8'd7, 8'd8); tick();
    drv_b(0, 0, 0, 0);
    ticks(2);
    chk("t6_pre_a", bus.a_count, 1);
    chk("t6_pre_b", bus.b_count, 2);
    rst = 1'b1; bus.mpq_busy = 1'b0; tick();
    chk("t6_acnt",  bus.a_count, 0);
    chk("t6_bcnt",  bus.b_count, 0);
    chk("t6_ardy",  bus.a_ready, 0);
    chk("t6_grant", bus.grant_b, 1);
    chk("t6_vld",   bus.mpq_cmd_valid, 0);
    rst = 1'b0; tick();
    st_cyc.delete(); pa_cyc.delete(); st_grant.delete();
    drv_a(1, 3'd2, 8'd9, 8'd9); tick(); drv_a(0, 0, 0, 0);
    wait_st(1, 10);
    if (st_cyc.size() >= 1 && pa_cyc.size() >= 1) begin
      chk("t6_lat",   st_cyc[0] - pa_cyc[0], 1);
      chk("t6_grnt0", st_grant[0], 0);
    end
    ticks(6);
    chk("t6_drain", st_cyc.size(), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mpq_cmd_sched.md
# mpq_cmd_sched

Command scheduler in front of the MPQ priority-queue engine. It buffers commands from two independent requesters (A, B) in per-source FIFOs and arbitrates between them round-robin. It issues one command at a time to MPQ using the MPQ `cmd_valid`/`busy` protocol. After a write-out command it waits for MPQ `done` before issuing anything further.

## Interface
- DEPTH, 4: entries per source FIFO (power of two, 2..16)
- TIMEOUT, 2: cycles after an issue within which `mpq_busy` must rise; otherwise the command counts as complete
- WR_CMD, 3'd4: command code of the MPQ write-out command

- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- a_valid  in  1  requester A command present
- a_ready  out  1  A FIFO can accept
- a_cmd / a_index / a_value  in  3/8/8  A command fields
- b_valid, b_ready, b_cmd, b_index, b_value  same widths  requester B
- mpq_busy  in  1  MPQ busy flag
- mpq_done  in  1  MPQ write-out complete
- mpq_cmd_valid  out  1  one-cycle issue strobe
- mpq_cmd / mpq_index / mpq_value  out  3/8/8  issued fields; 0 when strobe low
- grant_b  out  1  source of last issue (0=A, 1=B)
- seq_done  out  1  one-cycle pulse when write-out finishes
- a_count / b_count  out  5  FIFO occupancy

## Operation
- Push: when `x_valid & x_ready`, the entry {cmd,index,value} is written at the tail. `x_ready = !rst && count < DEPTH`.
- A full FIFO rejects the push even if a pop happens in the same cycle.
- Push and pop in the same cycle on a non-full FIFO leave the count unchanged.
- Pointers wrap modulo DEPTH.
- States: IDLE, WAIT, BUSY, FLUSH.
- IDLE: if `mpq_busy==0` and any FIFO is non-empty, select a source, pop its head, and register it onto the mpq outputs with `mpq_cmd_valid=1`.
  - Both FIFOs non-empty: pick the source with `!grant_b` (alternate).
  - One FIFO non-empty: pick it.
  - Update `grant_b` to the selected source.
  - Next state: FLUSH if the popped cmd == WR_CMD, else WAIT.
- WAIT: a counter starts at 1 on the issue cycle.
  - `mpq_busy==1` → BUSY.
  - Otherwise, when the counter reaches TIMEOUT → IDLE.
- BUSY: stay while `mpq_busy==1`; on `mpq_busy==0` → IDLE.
- FLUSH: ignore `mpq_busy`; on `mpq_done==1` pulse `seq_done` for one cycle and go to IDLE.
- FIFOs keep accepting pushes in every state.
- `mpq_cmd_valid` is high for exactly one cycle per issue. The mpq fields are driven 0 in all other cycles.

## Timing
- Reset values: all outputs 0, including `a_ready`/`b_ready` (0 while `rst` is high, 1 the cycle after), counts 0, `grant_b=1` (so A wins the first tie), state IDLE, FIFOs empty.
- `rst` mid-operation discards all FIFO contents and any in-flight wait. Outputs return to reset values at the next edge.
- Issue latency: an entry pushed at edge t into an empty FIFO, while in IDLE with `mpq_busy` low, has `mpq_cmd_valid=1` after edge t+1.
- Minimum spacing between issues:
  - TIMEOUT+1 cycles when busy never rises.
  - When busy rises: the issue after busy falls comes one cycle after BUSY→IDLE.
- Busy sampled high in IDLE blocks issue; nothing is popped.
- `mpq_done` outside FLUSH is ignored.
- `a_count`/`b_count` reflect the state after the current edge. Range is 0..DEPTH.

## Test plan
- A only: push (cmd1,idx0,val0), (cmd2,idx3,val9). Busy never rises → two strobes exactly TIMEOUT+1=3 cycles apart, fields match, `grant_b=0`.
- Both A and B pushed together, 2 entries each, after reset → issue order A0,B0,A1,B1. `grant_b` toggles 0,1,0,1.
- Busy handshake: after an issue, MPQ raises busy 1 cycle later and holds it 5 cycles → no strobe until 1 cycle after busy falls.
- Full: push 5 entries into A with no issue (hold busy high) → `a_ready=0` after the 4th push, `a_count=4`, 5th entry not stored.
- Write-out: issue cmd 3'd4, raise busy, pulse done 10 cycles later → no issue during FLUSH despite a queued B entry. `seq_done` pulses once; the B entry issues 1 cycle after leaving FLUSH.
- Reset mid-BUSY with 3 entries queued → counts 0, outputs 0, next pushed entry issues with latency 1.
